// File: rtl/card_dealer.sv
// Single-deck card dealer: LFSR-seeded start slot, linear probe over a 52-bit used-mask,
// one-cycle card presentation. Optional runtime reseed ports under CARD_DEALER_SEED_EN.
module card_dealer #(
  parameter logic [7:0] SEED         = 8'hA5,
  parameter int         AUTO_SHUFFLE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_req,
  input  logic       i_shuffle,
`ifdef CARD_DEALER_SEED_EN
  input  logic       i_seed_load,
  input  logic [7:0] i_seed,
`endif
  output logic [5:0] o_card,
  output logic [3:0] o_card_value,
  output logic       o_card_valid,
  output logic       o_busy,
  output logic       o_deck_empty,
  output logic [5:0] o_cards_left
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_PRESENT
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lfsr;
  logic [51:0] r_used;
  logic [5:0]  r_idx;
  logic [5:0]  r_cards_left;
  logic [5:0]  r_card;
  logic [3:0]  r_card_value;
  logic        r_card_valid;
  logic        r_busy;

  logic        w_lfsr_fb;
  logic [5:0]  w_start;
  logic [5:0]  w_next_idx;

  // Blackjack value via compare-subtract modulo 13: Ace=1, 2..10 face, J/Q/K=10.
  function automatic logic [3:0] value_of(input logic [5:0] c);
    logic [5:0] r;
    if (c >= 6'd39)      r = c - 6'd39;
    else if (c >= 6'd26) r = c - 6'd26;
    else if (c >= 6'd13) r = c - 6'd13;
    else                 r = c;
    return (r >= 6'd9) ? 4'd10 : (r[3:0] + 4'd1);
  endfunction

  assign w_lfsr_fb  = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_start    = (r_lfsr[5:0] >= 6'd52) ? (r_lfsr[5:0] - 6'd52) : r_lfsr[5:0];
  assign w_next_idx = (r_idx == 6'd51) ? 6'd0 : (r_idx + 6'd1);

  // Free-running LFSR, independent of the FSM so start slots keep moving while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED;
    end
`ifdef CARD_DEALER_SEED_EN
    else if (i_seed_load) begin
      r_lfsr <= (i_seed == 8'h00) ? SEED : i_seed;
    end
`endif
    else begin
      r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the used-mask must be reset: it is deck state, not a data buffer.
    if (rst) begin
      r_state      <= S_IDLE;
      r_used       <= '0;
      r_idx        <= '0;
      r_cards_left <= 6'd52;
      r_card       <= '0;
      r_card_value <= '0;
      r_card_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_card_valid <= 1'b0;
      if (i_shuffle) begin
        r_used       <= '0;
        r_cards_left <= 6'd52;
        r_state      <= S_IDLE;
        r_busy       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_req) begin
              if (r_cards_left != 6'd0) begin
                r_idx   <= w_start;
                r_state <= S_SEARCH;
                r_busy  <= 1'b1;
              end else if (AUTO_SHUFFLE != 0) begin
                r_used       <= '0;
                r_cards_left <= 6'd52;
                r_idx        <= w_start;
                r_state      <= S_SEARCH;
                r_busy       <= 1'b1;
              end
            end
          end
          S_SEARCH: begin
            if (r_used[r_idx]) begin
              r_idx <= w_next_idx;
            end else begin
              r_used[r_idx] <= 1'b1;
              r_card        <= r_idx;
              r_card_value  <= value_of(r_idx);
              r_cards_left  <= r_cards_left - 6'd1;
              r_card_valid  <= 1'b1;
              r_state       <= S_PRESENT;
            end
          end
          S_PRESENT: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_card       = r_card;
  assign o_card_value = r_card_value;
  assign o_card_valid = r_card_valid;
  assign o_busy       = r_busy;
  assign o_deck_empty = (r_cards_left == 6'd0);
  assign o_cards_left = r_cards_left;

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: scoreboard of predicted cards, table-driven deal rounds,
// plus hand-written empty-deck, shuffle-abort and (with CARD_DEALER_SEED_EN) reseed sequences.
module tb_card_dealer;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic shuffle = 1'b0;
`ifdef CARD_DEALER_SEED_EN
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
`endif

  logic [5:0] o_card, a_card;
  logic [3:0] o_card_value, a_card_value;
  logic       o_card_valid, a_card_valid;
  logic       o_busy, a_busy;
  logic       o_deck_empty, a_deck_empty;
  logic [5:0] o_cards_left, a_cards_left;

  card_dealer #(.SEED(SEED), .AUTO_SHUFFLE(0)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_shuffle(shuffle),
`ifdef CARD_DEALER_SEED_EN
    .i_seed_load(seed_load), .i_seed(seed),
`endif
    .o_card(o_card), .o_card_value(o_card_value), .o_card_valid(o_card_valid),
    .o_busy(o_busy), .o_deck_empty(o_deck_empty), .o_cards_left(o_cards_left)
  );

  card_dealer #(.SEED(SEED), .AUTO_SHUFFLE(1)) dut_as (
    .clk(clk), .rst(rst), .i_req(req), .i_shuffle(shuffle),
`ifdef CARD_DEALER_SEED_EN
    .i_seed_load(seed_load), .i_seed(seed),
`endif
    .o_card(a_card), .o_card_value(a_card_value), .o_card_valid(a_card_valid),
    .o_busy(a_busy), .o_deck_empty(a_deck_empty), .o_cards_left(a_cards_left)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference model: LFSR tracked cycle by cycle, deck mask updated at prediction time.
  logic [7:0]  m_lfsr;
  bit   [51:0] m_used;
  bit   [51:0] seen;
  int          m_left = 52;

  always @(posedge clk) begin
    if (rst) m_lfsr <= SEED;
`ifdef CARD_DEALER_SEED_EN
    else if (seed_load) m_lfsr <= (seed == 8'h00) ? SEED : seed;
`endif
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  typedef struct {
    int card;
    int value;
    int probes;
  } exp_t;
  exp_t sb[$];

  function automatic int value_of(input int c);
    int r;
    r = c % 13;
    return (r >= 9) ? 10 : r + 1;
  endfunction

  function automatic int start_slot(input logic [7:0] l);
    int s;
    s = int'(l[5:0]);
    return (s >= 52) ? s - 52 : s;
  endfunction

  task automatic push_prediction();
    exp_t e;
    int   idx;
    idx      = start_slot(m_lfsr);
    e.probes = 1;
    while (m_used[idx]) begin
      idx = (idx + 1) % 52;
      e.probes++;
    end
    m_used[idx] = 1'b1;
    m_left--;
    e.card  = idx;
    e.value = value_of(idx);
    sb.push_back(e);
  endtask

  task automatic clear_model();
    m_used = '0;
    seen   = '0;
    m_left = 52;
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after a posedge, DUT idle again.
  task automatic deal();
    exp_t e;
    bit   got;
    req = 1'b1;
    push_prediction();
    @(posedge clk); #1;
    req = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clk);
      if (k == 0) check("busy_in_search", o_busy, 1);
      if (o_card_valid) begin
        got = 1'b1;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("card_index", o_card, e.card);
          check("card_value", o_card_value, e.value);
          check("deal_latency", k, e.probes);
        end
        check("card_unique", seen[o_card], 0);
        seen[o_card] = 1'b1;
      end
    end
    if (!got) begin
      check("card_valid_timeout", 0, 1);
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    check("valid_one_cycle", o_card_valid, 0);
    check("cards_left_after_deal", o_cards_left, m_left);
  endtask

  task automatic shuffle_both();
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    clear_model();
    check("shuffle_cards_left", o_cards_left, 52);
    check("shuffle_busy", o_busy, 0);
    check("shuffle_empty", o_deck_empty, 0);
    check("shuffle_as_cards_left", a_cards_left, 52);
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    bit seen_valid;
    seen_valid = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (o_card_valid) seen_valid = 1'b1;
    end
    check(name, seen_valid, 0);
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit do_shuffle;
    int n_deals;
    int exp_left;
    bit exp_empty;
  } row_t;

`ifdef CARD_DEALER_SEED_EN
  typedef struct {
    logic [7:0] s;
    int         exp_card;
    int         exp_value;
  } seed_row_t;
`endif

  initial begin
    row_t rows[4];
    int   a_exp;
    bit   a_got;
    bit   d_got;
`ifdef CARD_DEALER_SEED_EN
    seed_row_t srows[5];
`endif

    rows[0] = '{do_shuffle: 1'b0, n_deals: 51, exp_left: 1,  exp_empty: 1'b0};
    rows[1] = '{do_shuffle: 1'b0, n_deals: 1,  exp_left: 0,  exp_empty: 1'b1};
    rows[2] = '{do_shuffle: 1'b1, n_deals: 7,  exp_left: 45, exp_empty: 1'b0};
    rows[3] = '{do_shuffle: 1'b1, n_deals: 52, exp_left: 0,  exp_empty: 1'b1};
`ifdef CARD_DEALER_SEED_EN
    srows[0] = '{s: 8'h00, exp_card: 37, exp_value: 10};
    srows[1] = '{s: 8'h40, exp_card: 0,  exp_value: 1};
    srows[2] = '{s: 8'h09, exp_card: 9,  exp_value: 10};
    srows[3] = '{s: 8'h0D, exp_card: 13, exp_value: 1};
    srows[4] = '{s: 8'h33, exp_card: 51, exp_value: 10};
`endif
    clear_model();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_card", o_card, 0);
    check("rst_card_value", o_card_value, 0);
    check("rst_card_valid", o_card_valid, 0);
    check("rst_busy", o_busy, 0);
    check("rst_deck_empty", o_deck_empty, 0);
    check("rst_cards_left", o_cards_left, 52);

    // First request straight after reset: slot 37, the Queen of suit 2
    deal();
    check("first_card_is_37", o_card, 37);
    check("first_value_is_10", o_card_value, 10);
    check("first_cards_left", o_cards_left, 51);

    // Drain the deck: every index exactly once
    for (int i = 0; i < 51; i++) deal();
    check("drained_cards_left", o_cards_left, 0);
    check("drained_empty", o_deck_empty, 1);
    check("all_52_seen", (seen == {52{1'b1}}), 1);

    // Request on empty deck: plain dealer stays silent, auto-shuffle dealer deals
    a_exp = start_slot(m_lfsr);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    a_got = 1'b0;
    d_got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_card_valid) d_got = 1'b1;
      if (a_card_valid && !a_got) begin
        a_got = 1'b1;
        check("as_card", a_card, a_exp);
        check("as_value", a_card_value, value_of(a_exp));
        check("as_latency", k, 1);
      end
    end
    @(posedge clk); #1;
    check("empty_req_no_valid", d_got, 0);
    check("as_dealt", a_got, 1);
    check("empty_req_cards_left", o_cards_left, 0);
    check("empty_req_busy", o_busy, 0);
    check("as_cards_left", a_cards_left, 51);
    check("as_deck_empty", a_deck_empty, 0);
    shuffle_both();

    // Shuffle while searching aborts the draw
    repeat (3) deal();
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    check("abort_busy_before", o_busy, 1);
    shuffle = 1'b1;
    @(posedge clk); #1;
    shuffle = 1'b0;
    clear_model();
    check("abort_valid", o_card_valid, 0);
    check("abort_busy_after", o_busy, 0);
    check("abort_cards_left", o_cards_left, 52);
    expect_quiet("abort_quiet", 5);

    // Shuffle and request in the same cycle: shuffle wins
    repeat (2) deal();
    req = 1'b1;
    shuffle = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    shuffle = 1'b0;
    clear_model();
    check("shuf_req_busy", o_busy, 0);
    check("shuf_req_cards_left", o_cards_left, 52);
    expect_quiet("shuf_req_quiet", 5);

    // Table-driven rounds, including the lone last card
    for (int r = 0; r < 4; r++) begin
      if (rows[r].do_shuffle) shuffle_both();
      repeat (rows[r].n_deals) deal();
      check("row_cards_left", o_cards_left, rows[r].exp_left);
      check("row_deck_empty", o_deck_empty, rows[r].exp_empty);
    end
    check("as_tracks_cards_left", a_cards_left, 0);
    check("as_tracks_empty", a_deck_empty, 1);

`ifdef CARD_DEALER_SEED_EN
    // Reseed together with shuffle; a zero seed falls back to SEED
    for (int r = 0; r < 5; r++) begin
      shuffle   = 1'b1;
      seed_load = 1'b1;
      seed      = srows[r].s;
      @(posedge clk); #1;
      shuffle   = 1'b0;
      seed_load = 1'b0;
      clear_model();
      deal();
      check("seed_card", o_card, srows[r].exp_card);
      check("seed_value", o_card_value, srows[r].exp_value);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
